// File: rtl/sha256d_nonce_scheduler.sv
// Double-SHA256 nonce search sequencer: drives one shared compression core
// through the header midstate, then first and second hash for every nonce.
module sha256d_nonce_scheduler #(
    parameter int TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] header,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         error,
    output logic [31:0]  result_nonce,
    output logic [255:0] result_hash,
    output logic         core_start,
    output logic         core_use_iv,
    output logic [255:0] core_chain,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_hash
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Expiry fires on the edge that would carry the timer to TIMEOUT
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        MID_REQ,
        MID_WAIT,
        H1_REQ,
        H1_WAIT,
        H2_REQ,
        H2_WAIT,
        CHECK,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [607:0]  hdr_q;
    logic [255:0]  target_q;
    logic [31:0]   nonce_end_q;
    logic [31:0]   nonce;
    logic [255:0]  midstate;
    logic [255:0]  h1;
    logic [TW-1:0] timer;

    logic waiting;
    logic expired;
    logic hit;
    logic last;
    logic stop;

    assign waiting = (state == MID_WAIT) || (state == H1_WAIT) ||
                     (state == H2_WAIT);
    assign expired = waiting && !core_done && (timer == T_LAST);
    assign hit     = (result_hash <= target_q);
    assign last    = (nonce == nonce_end_q);
    assign stop    = abort && busy;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (stop) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:     if (start) state_nx = MID_REQ;
                MID_REQ:  state_nx = MID_WAIT;
                MID_WAIT: begin
                    if (core_done)    state_nx = H1_REQ;
                    else if (expired) state_nx = IDLE;
                end
                H1_REQ:   state_nx = H1_WAIT;
                H1_WAIT: begin
                    if (core_done)    state_nx = H2_REQ;
                    else if (expired) state_nx = IDLE;
                end
                H2_REQ:   state_nx = H2_WAIT;
                H2_WAIT: begin
                    if (core_done)    state_nx = CHECK;
                    else if (expired) state_nx = IDLE;
                end
                CHECK:    state_nx = (hit || last) ? DONE : H1_REQ;
                DONE:     state_nx = IDLE;
                default:  state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            hdr_q        <= '0;
            target_q     <= '0;
            nonce_end_q  <= '0;
            nonce        <= '0;
            midstate     <= '0;
            h1           <= '0;
            timer        <= '0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            error        <= 1'b0;
            result_nonce <= '0;
            result_hash  <= '0;
        end else if (!stop) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hdr_q       <= header[639:32];
                        target_q    <= target;
                        nonce       <= nonce_start;
                        nonce_end_q <= nonce_end;
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        error       <= 1'b0;
                    end
                end
                MID_REQ, H1_REQ, H2_REQ: timer <= '0;
                MID_WAIT: begin
                    timer <= timer + 1'b1;
                    if (core_done)    midstate <= core_hash;
                    else if (expired) error    <= 1'b1;
                end
                H1_WAIT: begin
                    timer <= timer + 1'b1;
                    if (core_done)    h1    <= core_hash;
                    else if (expired) error <= 1'b1;
                end
                H2_WAIT: begin
                    timer <= timer + 1'b1;
                    if (core_done) begin
                        result_hash  <= core_hash;
                        result_nonce <= nonce;
                    end else if (expired) begin
                        error <= 1'b1;
                    end
                end
                CHECK: begin
                    if (hit)       found     <= 1'b1;
                    else if (last) exhausted <= 1'b1;
                    else           nonce     <= nonce + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Request fields stay up through the wait so the core may sample late
    always_comb begin
        busy        = (state != IDLE) && (state != DONE);
        core_start  = 1'b0;
        core_use_iv = 1'b0;
        core_chain  = '0;
        core_block  = '0;
        case (state)
            MID_REQ, MID_WAIT: begin
                core_start  = (state == MID_REQ);
                core_use_iv = 1'b1;
                core_block  = hdr_q[607:96];
            end
            H1_REQ, H1_WAIT: begin
                core_start = (state == H1_REQ);
                core_chain = midstate;
                core_block = {hdr_q[95:0], nonce, 1'b1, 319'b0, 64'd640};
            end
            H2_REQ, H2_WAIT: begin
                core_start  = (state == H2_REQ);
                core_use_iv = 1'b1;
                core_block  = {h1, 1'b1, 191'b0, 64'd256};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sha256d_nonce_scheduler.sv
// Randomized bench for sha256d_nonce_scheduler with a behavioural core
// and a job-level reference model of the nonce search.
module tb_sha256d_nonce_scheduler;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [639:0] header = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic         error;
    logic [31:0]  result_nonce;
    logic [255:0] result_hash;
    logic         core_start;
    logic         core_use_iv;
    logic [255:0] core_chain;
    logic [511:0] core_block;
    logic         core_done = 1'b0;
    logic [255:0] core_hash = '0;

    sha256d_nonce_scheduler #(.TIMEOUT(255)) dut (
        .CLK(CLK), .reset(reset), .start(start), .abort(abort),
        .header(header), .target(target),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .busy(busy), .found(found), .exhausted(exhausted), .error(error),
        .result_nonce(result_nonce), .result_hash(result_hash),
        .core_start(core_start), .core_use_iv(core_use_iv),
        .core_chain(core_chain), .core_block(core_block),
        .core_done(core_done), .core_hash(core_hash)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         use_iv;
        logic [255:0] chain;
        logic [511:0] block;
    } req_t;

    localparam int M_MIX  = 0;
    localparam int M_HIT  = 1;
    localparam int M_ONES = 2;

    req_t        obs_q[$];
    req_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_starts = 0;
    int          lc = 4;
    int          mode = M_MIX;
    bit          core_en = 1'b1;
    bit          spur = 1'b0;
    int          cnt = 0;
    logic [255:0] resp = '0;
    logic [31:0]  lastn = '0;

    task automatic check(input string tag, input logic [511:0] got,
                         input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] core_fn(input int md, input logic use_iv,
                                             input logic [255:0] chain,
                                             input logic [511:0] blk,
                                             input logic [31:0] ln);
        logic [255:0] h;
        case (md)
            M_HIT: begin
                if (use_iv) h = (ln == 32'h12) ? '0 : '1;
                else        h = (blk[415:384] == 32'h12) ? '0 : '1;
            end
            M_ONES: h = '1;
            default: begin
                h = chain ^ blk[511:256] ^ {blk[127:0], blk[255:128]};
                if (use_iv) h = h ^ {8{32'h6a09e667}};
                h = h + {h[100:0], h[255:101]};
            end
        endcase
        return h;
    endfunction

    function automatic logic [639:0] rand_hdr();
        logic [639:0] h;
        for (int i = 0; i < 20; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    // Behavioural core: answers each launch lc cycles later
    always @(negedge CLK) begin
        req_t r;
        core_done = 1'b0;
        if (spur) begin
            core_done = 1'b1;
            core_hash = '1;
        end
        if (reset) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_hash = resp;
                end
            end
            if (core_start) begin
                r.use_iv = core_use_iv;
                r.chain  = core_chain;
                r.block  = core_block;
                obs_q.push_back(r);
                n_starts++;
                if (core_en) begin
                    resp = core_fn(mode, core_use_iv, core_chain,
                                   core_block, lastn);
                    cnt = lc;
                end
                if (!core_use_iv) lastn = core_block[415:384];
            end
        end
    end

    task automatic ref_job(input logic [639:0] hdr, input logic [255:0] tgt,
                           input logic [31:0] ns, input logic [31:0] ne,
                           input int md, output bit f, output bit ex,
                           output logic [31:0] rn, output logic [255:0] rh,
                           output int nt);
        logic [255:0] mid, hh1, hh2;
        logic [511:0] b;
        logic [31:0]  n, ln;
        req_t r;
        exp_q.delete();
        f = 0; ex = 0; nt = 0; ln = '0; rn = '0; rh = '0;
        r.use_iv = 1'b1; r.chain = '0; r.block = hdr[639:128];
        exp_q.push_back(r);
        mid = core_fn(md, 1'b1, '0, hdr[639:128], ln);
        n = ns;
        for (int i = 0; i < 64; i++) begin
            b = {hdr[127:32], n, 1'b1, 319'b0, 64'd640};
            r.use_iv = 1'b0; r.chain = mid; r.block = b;
            exp_q.push_back(r);
            hh1 = core_fn(md, 1'b0, mid, b, ln);
            ln = n;
            b = {hh1, 1'b1, 191'b0, 64'd256};
            r.use_iv = 1'b1; r.chain = '0; r.block = b;
            exp_q.push_back(r);
            hh2 = core_fn(md, 1'b1, '0, b, ln);
            nt++;
            rn = n;
            rh = hh2;
            if (hh2 <= tgt) begin f = 1; break; end
            if (n == ne) begin ex = 1; break; end
            n = n + 32'd1;
        end
    endtask

    task automatic run_job(input string tag, input logic [639:0] hdr,
                           input logic [255:0] tgt, input logic [31:0] ns,
                           input logic [31:0] ne, input int md, input int l,
                           input bit inject);
        bit f, ex;
        logic [31:0]  rn;
        logic [255:0] rh;
        int nt, cyc, s0, m;
        ref_job(hdr, tgt, ns, ne, md, f, ex, rn, rh, nt);
        mode = md; lc = l; core_en = 1'b1; lastn = '0;
        obs_q.delete();
        s0 = n_starts;
        header = hdr; target = tgt; nonce_start = ns; nonce_end = ne;
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(negedge CLK);
        cyc = 0;
        while (busy === 1'b1 && cyc < 4000) begin
            cyc++;
            if (inject && cyc == 2) begin
                start = 1'b1; header = rand_hdr(); target = '1;
                nonce_start = '0; nonce_end = '1;
            end
            if (inject && cyc == 4) start = 1'b0;
            @(negedge CLK);
        end
        start = 1'b0;
        check({tag, "_bound"}, cyc < 4000, 1);
        check({tag, "_cycles"}, cyc, (l + 1) + nt * (2 * l + 3));
        check({tag, "_found"}, found, f);
        check({tag, "_exh"}, exhausted, ex);
        check({tag, "_err"}, error, 0);
        check({tag, "_rnonce"}, result_nonce, rn);
        check({tag, "_rhash"}, result_hash, rh);
        check({tag, "_starts"}, n_starts - s0, exp_q.size());
        check({tag, "_reqs"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check({tag, "_iv"}, obs_q[i].use_iv, exp_q[i].use_iv);
            check({tag, "_chain"}, obs_q[i].chain, exp_q[i].chain);
            check({tag, "_block"}, obs_q[i].block, exp_q[i].block);
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_exh"}, exhausted, 0);
        check({tag, "_err"}, error, 0);
        check({tag, "_rnonce"}, result_nonce, 0);
        check({tag, "_rhash"}, result_hash, 0);
        check({tag, "_cstart"}, core_start, 0);
        check({tag, "_civ"}, core_use_iv, 0);
        check({tag, "_cchain"}, core_chain, 0);
        check({tag, "_cblock"}, core_block, 0);
    endtask

    task automatic wait_starts(input string tag, input int n);
        int k = 0;
        while (n_starts < n && k < 300) begin
            @(negedge CLK); #1;
            k++;
        end
        check(tag, n_starts >= n, 1);
    endtask

    initial begin
        logic [31:0] ns;
        int s0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("rst");
        @(posedge CLK); #1 reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        run_job("mid", rand_hdr(), rand256(), 32'd7, 32'd7, M_MIX, 4, 1'b0);

        run_job("hit", rand_hdr(), 256'h1, 32'h10, 32'h20, M_HIT, 4, 1'b0);
        check("hit_nonce", result_nonce, 32'h12);
        check("hit_hash", result_hash, 0);
        check("hit_found", found, 1);
        check("hit_nstart", obs_q.size(), 7);

        run_job("wrap", rand_hdr(), 256'h0, 32'hFFFFFFFE, 32'h1, M_ONES, 4,
                1'b0);
        check("wrap_exh", exhausted, 1);
        check("wrap_found", found, 0);
        check("wrap_nonce", result_nonce, 32'h1);
        check("wrap_nstart", obs_q.size(), 9);

        for (int i = 0; i < 20; i++) begin
            ns = (i % 4 == 0) ? 32'hFFFFFFFF - $urandom_range(0, 2) : $urandom;
            run_job("rnd", rand_hdr(), rand256(), ns,
                    ns + $urandom_range(0, 3), M_MIX,
                    int'($urandom_range(1, 6)), (i % 3) == 0);
        end

        // Core never answers
        core_en = 1'b0;
        s0 = n_starts;
        header = rand_hdr(); nonce_start = 1; nonce_end = 2;
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(negedge CLK);
        repeat (255) @(negedge CLK);
        check("to_busy_before", busy, 1);
        check("to_err_before", error, 0);
        @(negedge CLK);
        check("to_busy", busy, 0);
        check("to_err", error, 1);
        repeat (20) @(negedge CLK);
        check("to_nstart", n_starts - s0, 1);
        check("to_err_hold", error, 1);
        @(posedge CLK); #1;
        core_en = 1'b1;

        // Abort in H1_WAIT; the late done must be ignored
        mode = M_MIX; lc = 6;
        s0 = n_starts;
        header = rand_hdr(); target = '0; nonce_start = 0; nonce_end = 5;
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        wait_starts("ab_h1", s0 + 2);
        @(posedge CLK); #1 abort = 1'b1;
        @(posedge CLK); #1 abort = 1'b0;
        @(negedge CLK);
        check("ab_busy", busy, 0);
        check("ab_err", error, 0);
        check("ab_found", found, 0);
        check("ab_exh", exhausted, 0);
        repeat (12) @(negedge CLK);
        check("ab_late_busy", busy, 0);
        check("ab_late_nstart", n_starts - s0, 2);
        @(posedge CLK); #1 spur = 1'b1;
        @(posedge CLK); #1 spur = 1'b0;
        repeat (3) @(negedge CLK);
        check("spur_busy", busy, 0);
        check("spur_nstart", n_starts - s0, 2);
        @(posedge CLK); #1;

        // Synchronous reset in H2_WAIT
        lc = 4;
        s0 = n_starts;
        header = rand_hdr(); target = rand256();
        nonce_start = 100; nonce_end = 110;
        start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        wait_starts("rr_h2", s0 + 3);
        @(posedge CLK); #1 reset = 1'b1;
        @(posedge CLK); #1 reset = 1'b0;
        @(negedge CLK);
        check_zero("rr");
        @(posedge CLK); #1;
        run_job("post", rand_hdr(), rand256(), 32'd50, 32'd52, M_MIX, 3,
                1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
